// File: rtl/e3_serial_add_ctrl.sv
// Digit-serial excess-3 BCD adder: one XS-3 digit per clock, LSD first, valid/ready in and out.
// Define E3_DIGIT_CHECK_EN to build the invalid-input-digit checker that drives err.
module e3_serial_add_ctrl #(
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_a,
  input  logic [4*DIGITS-1:0]   in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS+3:0]   out_sum,
  output logic                  busy,
  output logic                  err
);

  localparam int IW = $clog2(DIGITS + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [4*DIGITS-1:0] a_sh;
  logic [4*DIGITS-1:0] b_sh;
  logic                carry;
  logic [IW-1:0]       idx;
  logic [4:0]          s5;
  logic [3:0]          digit;
  logic                last_digit;
  logic                accept;

  // The XS-3 bias is removed on a no-carry digit and re-applied when a decimal carry leaves it.
  assign s5         = {1'b0, a_sh[3:0]} + {1'b0, b_sh[3:0]} + {4'b0000, carry};
  assign digit      = s5[4] ? (s5[3:0] + 4'd3) : (s5[3:0] - 4'd3);
  assign last_digit = (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_digit) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The carry digit is written on the last RUN edge so out_sum is complete the moment DONE starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      carry   <= 1'b0;
      idx     <= '0;
      out_sum <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sh  <= in_a;
            b_sh  <= in_b;
            carry <= 1'b0;
            idx   <= '0;
          end
        end
        RUN: begin
          out_sum[{idx, 2'b00} +: 4] <= digit;
          carry <= s5[4];
          a_sh  <= a_sh >> 4;
          b_sh  <= b_sh >> 4;
          idx   <= idx + 1'b1;
          if (last_digit) out_sum[4*DIGITS +: 4] <= s5[4] ? 4'b0100 : 4'b0011;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef E3_DIGIT_CHECK_EN
  logic err_q;
  logic bad_digit;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((in_a[4*i +: 4] < 4'd3) || (in_a[4*i +: 4] > 4'd12) ||
          (in_b[4*i +: 4] < 4'd3) || (in_b[4*i +: 4] > 4'd12))
        bad_digit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                         err_q <= 1'b0;
    else if (accept)                 err_q <= bad_digit;
    else if (out_valid && out_ready) err_q <= 1'b0;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
